// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM duty sequencer: register map, CTRL/STATUS bit
// positions and the playback FSM encoding.
package pwm_seq_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h1;
  localparam logic [3:0] ADDR_PERIOD = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_ZOU    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLUSH  = 3;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_UNDERRUN = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pwm_seq_fifo.sv
// Synchronous DEPTHx8 sample FIFO with flush. Full/empty decisions use the
// pre-cycle level, so a pop on a full FIFO frees room for a same-cycle push.
module pwm_seq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);
  import pwm_seq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && !flush && (!full || do_pop);
    overflow = push && !flush && full && !do_pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Memory-mapped duty streamer: software queues 8-bit duty samples, one is
// released every PERIOD+1 PWM frames, aligned to the PWM counter wrap.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | EN=0; duty_out forced 0, frame counter held at 0
//   ST_WAIT | EN=1, no active sample; next tick with data loads one
//   ST_RUN  | sample playing; counting frames until the next pop
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       frame_tick,
  output logic [7:0] duty_out,
  output logic       duty_load,
  output logic       irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic       en_q, en_d;
  logic       zou_q, zou_d;
  logic       irq_en_q, irq_en_d;
  logic [7:0] period_q, period_d;
  logic       underrun_q, underrun_d;
  logic       overflow_q, overflow_d;
  seq_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] duty_q, duty_d;
  logic       load_q, load_d;

  logic          wr_data, wr_ctrl, wr_period, wr_status;
  logic          fifo_pop, fifo_flush, fifo_empty, fifo_full, fifo_ovf;
  logic [7:0]    fifo_rd;
  logic [LW-1:0] fifo_level;
  logic          underrun_set;

  assign wr_data    = data_write && (address == ADDR_DATA);
  assign wr_ctrl    = data_write && (address == ADDR_CTRL);
  assign wr_period  = data_write && (address == ADDR_PERIOD);
  assign wr_status  = data_write && (address == ADDR_STATUS);
  assign fifo_flush = wr_ctrl && data_in[CTRL_FLUSH];

  pwm_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_data),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .wr_data  (data_in),
    .rd_data  (fifo_rd),
    .level    (fifo_level),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_ovf)
  );

  always_comb begin
    en_d     = en_q;
    zou_d    = zou_q;
    irq_en_d = irq_en_q;
    period_d = period_q;
    if (wr_ctrl) begin
      en_d     = data_in[CTRL_EN];
      zou_d    = data_in[CTRL_ZOU];
      irq_en_d = data_in[CTRL_IRQ_EN];
    end
    if (wr_period) period_d = data_in;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    duty_d       = duty_q;
    load_d       = 1'b0;
    fifo_pop     = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        duty_d = '0;
        if (en_d) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_tick && !fifo_empty) begin
          fifo_pop = 1'b1;
          duty_d   = fifo_rd;
          load_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          // Terminal compare as >= so a PERIOD lowered mid-sample cannot
          // push the counter through 255 before it matches again.
          if (cnt_q < period_q) begin
            cnt_d = cnt_q + 8'd1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            duty_d   = fifo_rd;
            load_d   = 1'b1;
            cnt_d    = '0;
          end else begin
            underrun_set = 1'b1;
            state_d      = ST_WAIT;
            if (zou_q) begin
              duty_d = '0;
              load_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling wins over any frame activity in the same cycle.
    if (!en_d && state_q != ST_IDLE) begin
      state_d      = ST_IDLE;
      fifo_pop     = 1'b0;
      underrun_set = 1'b0;
      cnt_d        = '0;
      duty_d       = '0;
      load_d       = 1'b1;
    end
  end

  always_comb begin
    underrun_d = (underrun_q && !(wr_status && data_in[STAT_UNDERRUN])) || underrun_set;
    overflow_d = (overflow_q && !(wr_status && data_in[STAT_OVERFLOW])) || fifo_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      zou_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      load_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      zou_q      <= zou_d;
      irq_en_q   <= irq_en_d;
      period_q   <= period_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      load_q     <= load_d;
    end
  end

  assign duty_out  = duty_q;
  assign duty_load = load_q;
  assign irq       = irq_en_q && en_q &&
                     ((fifo_level <= LW'(DEPTH / 2)) || underrun_q);

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_DATA:   data_out = 8'(fifo_level);
      ADDR_CTRL:   data_out = {5'b0, irq_en_q, zou_q, en_q};
      ADDR_PERIOD: data_out = period_q;
      ADDR_STATUS: data_out = {4'b0, overflow_q, underrun_q, fifo_full, fifo_empty};
      default:     data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: directed scenarios plus random
// register/tick traffic, all scored against a sample-queue reference model.
module tb_pwm_duty_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] address = '0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = '0;
  logic       frame_tick = 1'b0;
  logic [7:0] data_out;
  logic [7:0] duty_out;
  logic       duty_load;
  logic       irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pwm_duty_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .frame_tick (frame_tick),
    .duty_out   (duty_out),
    .duty_load  (duty_load),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: the queue holds pending samples; a sample is "playing"
  // once loaded and is replaced after period+1 frames.
  logic [7:0] m_q[$];
  logic       m_en, m_zou, m_ien, m_unr, m_ovf, m_playing, m_load;
  logic [7:0] m_period, m_duty;
  int         m_frames;

  task automatic model_reset();
    m_q.delete();
    m_en = 0; m_zou = 0; m_ien = 0; m_unr = 0; m_ovf = 0;
    m_playing = 0; m_load = 0; m_period = 0; m_duty = 0; m_frames = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic w, input logic [7:0] d,
                            input logic t);
    int   lvl;
    logic push, flush, new_en, do_pop, unr_set, ovf_set;
    lvl     = m_q.size();
    push    = w && (a == 4'h0);
    flush   = w && (a == 4'h1) && d[3];
    new_en  = (w && a == 4'h1) ? d[0] : m_en;
    do_pop  = 0; unr_set = 0; ovf_set = 0;
    m_load  = 0;
    if (m_en && !new_en) begin
      m_duty = 0; m_load = 1; m_playing = 0;
    end else if (m_en && t) begin
      if (!m_playing || m_frames >= int'(m_period)) begin
        if (lvl > 0) begin
          do_pop = 1; m_duty = m_q[0]; m_load = 1; m_playing = 1; m_frames = 0;
        end else if (m_playing) begin
          unr_set = 1; m_playing = 0;
          if (m_zou) begin m_duty = 0; m_load = 1; end
        end
      end else begin
        m_frames++;
      end
    end
    if (flush) m_q.delete();
    else begin
      if (do_pop) void'(m_q.pop_front());
      if (push) begin
        if (lvl < DEPTH || do_pop) m_q.push_back(d);
        else ovf_set = 1;
      end
    end
    if (w && a == 4'h1) begin m_zou = d[1]; m_ien = d[2]; end
    m_en = new_en;
    if (w && a == 4'h2) m_period = d;
    m_unr = (m_unr && !(w && a == 4'h3 && d[2])) || unr_set;
    m_ovf = (m_ovf && !(w && a == 4'h3 && d[3])) || ovf_set;
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      4'h0: r = 8'(m_q.size());
      4'h1: r = {5'b0, m_ien, m_zou, m_en};
      4'h2: r = m_period;
      4'h3: r = {4'b0, m_ovf, m_unr, (m_q.size() == DEPTH), (m_q.size() == 0)};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic model_irq();
    return m_ien && m_en && ((m_q.size() <= DEPTH / 2) || m_unr);
  endfunction

  // One clock of stimulus; outputs are scored against the model 1ns after the edge.
  task automatic drive_cycle(input logic [3:0] a, input logic w, input logic [7:0] d,
                             input logic t);
    logic [7:0] exp_rd;
    @(negedge clk);
    address = a; data_write = w; data_in = d; frame_tick = t;
    @(posedge clk);
    model_step(a, w, d, t);
    #1;
    cyc++;
    data_write = 0; frame_tick = 0;
    exp_rd = model_read(a);
    checks++;
    if (duty_out !== m_duty) begin
      failures++; $display("FAIL duty_out cyc=%0d got=%02h exp=%02h", cyc, duty_out, m_duty);
    end
    checks++;
    if (duty_load !== m_load) begin
      failures++; $display("FAIL duty_load cyc=%0d got=%0b exp=%0b", cyc, duty_load, m_load);
    end
    checks++;
    if (irq !== model_irq()) begin
      failures++; $display("FAIL irq cyc=%0d got=%0b exp=%0b", cyc, irq, model_irq());
    end
    checks++;
    if (data_out !== exp_rd) begin
      failures++; $display("FAIL data_out cyc=%0d addr=%0h got=%02h exp=%02h", cyc, a, data_out, exp_rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(4'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    logic [7:0] exp_rd[4];
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(4'(i), 1'b0, 8'h00, 1'b0);
      checks++;
      if (data_out !== exp_rd[i]) begin
        failures++; $display("FAIL reset_read addr=%0d got=%02h exp=%02h", i, data_out, exp_rd[i]);
      end
    end
    checks++;
    if (duty_out !== 8'h00 || irq !== 1'b0) begin
      failures++; $display("FAIL reset_outputs duty=%02h irq=%0b exp 00/0", duty_out, irq);
    end
  endtask

  task automatic test_playback();
    logic [7:0] exp_duty[8];
    exp_duty[1] = 8'h10; exp_duty[2] = 8'h10; exp_duty[3] = 8'h80; exp_duty[4] = 8'h80;
    exp_duty[5] = 8'hFF; exp_duty[6] = 8'hFF; exp_duty[7] = 8'hFF;
    drive_cycle(4'h0, 1'b1, 8'h10, 1'b0);
    drive_cycle(4'h0, 1'b1, 8'h80, 1'b0);
    drive_cycle(4'h0, 1'b1, 8'hFF, 1'b0);
    drive_cycle(4'h2, 1'b1, 8'h01, 1'b0);
    drive_cycle(4'h1, 1'b1, 8'h01, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      idle(255);
      drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (duty_out !== exp_duty[k] || duty_load !== (k == 1 || k == 3 || k == 5)) begin
        failures++;
        $display("FAIL playback tick=%0d duty=%02h load=%0b exp_duty=%02h", k, duty_out, duty_load, exp_duty[k]);
      end
      idle(1);
      checks++;
      if (duty_load !== 1'b0) begin
        failures++; $display("FAIL load_width tick=%0d got=%0b exp=0", k, duty_load);
      end
    end
    drive_cycle(4'h0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h00) begin
      failures++; $display("FAIL end_level got=%02h exp=00", data_out);
    end
    drive_cycle(4'h3, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h05 || duty_out !== 8'hFF) begin
      failures++; $display("FAIL underrun status=%02h duty=%02h exp 05/ff", data_out, duty_out);
    end
  endtask

  task automatic test_underrun_zero();
    drive_cycle(4'h1, 1'b1, 8'h03, 1'b0);
    drive_cycle(4'h3, 1'b1, 8'h04, 1'b0);
    drive_cycle(4'h0, 1'b1, 8'h22, 1'b0);
    idle(5); drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (duty_out !== 8'h22) begin
      failures++; $display("FAIL zou_load got=%02h exp=22", duty_out);
    end
    idle(5); drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
    idle(5); drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (duty_out !== 8'h00 || duty_load !== 1'b1) begin
      failures++; $display("FAIL zou_underrun duty=%02h load=%0b exp 00/1", duty_out, duty_load);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(4'h1, 1'b1, 8'h08, 1'b0);
    drive_cycle(4'h3, 1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(4'h0, 1'b1, 8'hA1 + 8'(i), 1'b0);
    drive_cycle(4'h0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h04) begin
      failures++; $display("FAIL ovf_level got=%02h exp=04", data_out);
    end
    drive_cycle(4'h3, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h0A) begin
      failures++; $display("FAIL ovf_status got=%02h exp=0a", data_out);
    end
    drive_cycle(4'h3, 1'b1, 8'h08, 1'b0);
    checks++;
    if (data_out !== 8'h02) begin
      failures++; $display("FAIL ovf_clear got=%02h exp=02", data_out);
    end
    drive_cycle(4'h2, 1'b1, 8'h00, 1'b0);
    drive_cycle(4'h1, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(3); drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (duty_out !== ((i < 4) ? 8'hA1 + 8'(i) : 8'hA4)) begin
        failures++; $display("FAIL ovf_playback pop=%0d got=%02h", i, duty_out);
      end
    end
  endtask

  task automatic test_full_pushpop_flush();
    drive_cycle(4'h1, 1'b1, 8'h00, 1'b0);
    drive_cycle(4'h1, 1'b1, 8'h08, 1'b0);
    drive_cycle(4'h3, 1'b1, 8'h0C, 1'b0);
    drive_cycle(4'h2, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(4'h0, 1'b1, 8'hB1 + 8'(i), 1'b0);
    drive_cycle(4'h1, 1'b1, 8'h01, 1'b0);
    drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
    drive_cycle(4'h0, 1'b1, 8'hB5, 1'b0);
    drive_cycle(4'h0, 1'b1, 8'hB6, 1'b1);
    checks++;
    if (data_out !== 8'h04 || duty_out !== 8'hB2) begin
      failures++; $display("FAIL full_pushpop level=%02h duty=%02h exp 04/b2", data_out, duty_out);
    end
    drive_cycle(4'h3, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h02) begin
      failures++; $display("FAIL full_pushpop_status got=%02h exp=02", data_out);
    end
    drive_cycle(4'h1, 1'b1, 8'h09, 1'b0);
    drive_cycle(4'h0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h00 || duty_out !== 8'hB2) begin
      failures++; $display("FAIL flush level=%02h duty=%02h exp 00/b2", data_out, duty_out);
    end
  endtask

  task automatic test_irq();
    drive_cycle(4'h1, 1'b1, 8'h08, 1'b0);
    drive_cycle(4'h3, 1'b1, 8'h0C, 1'b0);
    drive_cycle(4'h2, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(4'h0, 1'b1, 8'h3C + 8'(i), 1'b0);
    drive_cycle(4'h1, 1'b1, 8'h05, 1'b0);
    idle(2);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_level3 got=%0b exp=0", irq);
    end
    drive_cycle(4'h0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (irq !== 1'b1 || duty_out !== 8'h3C) begin
      failures++; $display("FAIL irq_level2 irq=%0b duty=%02h exp 1/3c", irq, duty_out);
    end
    drive_cycle(4'h1, 1'b1, 8'h04, 1'b0);
    checks++;
    if (duty_out !== 8'h00 || duty_load !== 1'b1 || irq !== 1'b0) begin
      failures++; $display("FAIL disable duty=%02h load=%0b irq=%0b exp 00/1/0", duty_out, duty_load, irq);
    end
    idle(1);
    checks++;
    if (duty_load !== 1'b0) begin
      failures++; $display("FAIL disable_load_width got=%0b exp=0", duty_load);
    end
  endtask

  task automatic test_random(input int n);
    logic [3:0] a;
    logic       w, t;
    logic [7:0] d;
    int         r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      t = ($urandom_range(0, 4) == 0);
      a = 4'h0; w = 1'b0; d = 8'h00;
      if (r < 35) begin
        w = 1'b1; d = 8'($urandom);
      end else if (r < 43) begin
        a = 4'h1; w = 1'b1;
        d[0] = ($urandom_range(0, 7) != 0);
        d[1] = 1'($urandom_range(0, 1));
        d[2] = 1'($urandom_range(0, 1));
        d[3] = ($urandom_range(0, 9) == 0);
      end else if (r < 48) begin
        a = 4'h3; w = 1'b1; d = 8'($urandom_range(0, 15));
      end else if (r < 52 && !m_en) begin
        a = 4'h2; w = 1'b1; d = 8'($urandom_range(0, 3));
      end else if (r < 60) begin
        a = 4'($urandom_range(4, 15)); w = 1'b1; d = 8'($urandom);
      end else begin
        a = 4'($urandom_range(0, 15));
      end
      drive_cycle(a, w, d, t);
    end
  endtask

  task automatic test_async_reset();
    test_random(200);
    @(negedge clk);
    address = 4'h3;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (duty_out !== 8'h00 || duty_load !== 1'b0 || irq !== 1'b0 || data_out !== 8'h01) begin
      failures++;
      $display("FAIL async_reset duty=%02h load=%0b irq=%0b status=%02h", duty_out, duty_load, irq, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_cycle(4'h0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (data_out !== 8'h00) begin
      failures++; $display("FAIL post_reset_level got=%02h exp=00", data_out);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_playback();
    test_underrun_zero();
    test_overflow();
    test_full_pushpop_flush();
    test_irq();
    test_random(3000);
    test_async_reset();
    test_random(500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
